// File: rtl/beta_pkg.sv
// Shared constants for the Beta fetch unit: PC vectors, PCSEL codes, FSM states.
package beta_pkg;

    localparam logic [31:0] RESET_VEC_D = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_D = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_D  = 32'h8000_0008;

    localparam logic [2:0] PCSEL_PC4    = 3'b000;
    localparam logic [2:0] PCSEL_PC4SXT = 3'b001;
    localparam logic [2:0] PCSEL_JT     = 3'b010;
    localparam logic [2:0] PCSEL_ILLOP  = 3'b011;
    localparam logic [2:0] PCSEL_XADR   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/beta_next_pc.sv
// Combinational next-PC logic: PC+4, branch target and the PCSEL/IRQ selection.
// Bit 31 (supervisor flag) never takes part in the address arithmetic.
module beta_next_pc
    import beta_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_D,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_D
) (
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [31:0] jt,
    input  logic [2:0]  pcsel,
    input  logic        irq,
    output logic [31:0] pc4,
    output logic [31:0] pc4sxt,
    output logic [31:0] next_pc
);

    logic [31:0] sxt;
    logic        unused_jt;

    // Word offset of the branch literal, already scaled to bytes.
    assign sxt    = {{14{imm[15]}}, imm, 2'b00};
    assign pc4    = {pc[31], pc[30:0] + 31'd4};
    assign pc4sxt = {pc[31], pc4[30:0] + sxt[30:0]};

    // JMP targets are forced word-aligned, so the low two bits of JT are dropped.
    assign unused_jt = &{1'b0, jt[1:0]};

    // Select next PC; an unmasked interrupt overrides every PCSEL code.
    always_comb begin
        next_pc = ILLOP_VEC;
        if (irq && !pc[31]) begin
            next_pc = XADR_VEC;
        end else begin
            case (pcsel)
                PCSEL_PC4:    next_pc = pc4;
                PCSEL_PC4SXT: next_pc = pc4sxt;
                PCSEL_JT:     next_pc = {pc[31] & jt[31], jt[30:2], 2'b00};
                PCSEL_ILLOP:  next_pc = ILLOP_VEC;
                PCSEL_XADR:   next_pc = XADR_VEC;
                default:      next_pc = ILLOP_VEC;
            endcase
        end
    end

endmodule

// File: rtl/beta_fetch_unit.sv
// PC register and instruction-fetch sequencer (IDLE -> FETCH <-> HOLD).
// IMEM_REQ is decoded from state so an async reset drops it immediately.
module beta_fetch_unit
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_D,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_D,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_D
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  pcsel,
    input  logic [31:0] jt,
    input  logic        irq,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] pc4sxt
);

    fetch_state_e state, state_nxt;
    logic [31:0]  next_pc;
    logic         ack_take;
    logic         adv_take;

    assign ack_take  = (state == S_FETCH) && imem_ack;
    assign adv_take  = (state == S_HOLD) && advance;
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;

    beta_next_pc #(
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_next_pc (
        .pc      (pc),
        .imm     (instr[15:0]),
        .jt      (jt),
        .pcsel   (pcsel),
        .irq     (irq),
        .pc4     (pc4),
        .pc4sxt  (pc4sxt),
        .next_pc (next_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: fetch once out of reset, hold after ACK, refetch on ADVANCE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) state_nxt = S_HOLD;
            S_HOLD:  if (advance)  state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // PC, INSTR and INSTR_VALID registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_VEC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            if (ack_take) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (adv_take) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed plus randomized bench for beta_fetch_unit with a transaction-level PC model.
module tb_beta_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  pcsel = 3'd0;
    logic [31:0] jt = 32'h0;
    logic        irq = 1'b0;
    logic        advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc4sxt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    beta_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pcsel       (pcsel),
        .jt          (jt),
        .irq         (irq),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc4         (pc4),
        .pc4sxt      (pc4sxt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: low 31 bits wrap, bit 31 carried over unchanged.
    function automatic logic [31:0] keep31(input logic [31:0] p, input logic [31:0] sum);
        return (p & 32'h8000_0000) | (sum & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_pc4(input logic [31:0] p);
        return keep31(p, p + 32'd4);
    endfunction

    function automatic logic [31:0] ref_br(input logic [31:0] p, input logic [31:0] w);
        int off;
        off = int'($signed(w[15:0])) * 4;
        return keep31(p, p + 32'd4 + 32'(off));
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic [2:0] sel, input logic [31:0] j,
                                             input logic ir);
        if (ir && p < 32'h8000_0000) return 32'h8000_0008;
        case (sel)
            3'd0:    return ref_pc4(p);
            3'd1:    return ref_br(p, w);
            3'd2:    return (j & 32'h7FFF_FFFC) | (p & j & 32'h8000_0000);
            3'd4:    return 32'h8000_0008;
            default: return 32'h8000_0004;
        endcase
    endfunction

    // One fetch starting at a negedge where FETCH is expected; ACK after 'delay' cycles.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int d = 0; d < delay; d++) begin
            advance = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_req", {31'b0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, exp_addr);
        end
        advance    = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        m_instr  = word;
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_instr", instr, word);
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        chk("hold_pc", pc, m_pc);
        chk("hold_pc4", pc4, ref_pc4(m_pc));
        chk("hold_pc4sxt", pc4sxt, ref_br(m_pc, word));
        // A stray ACK in HOLD must not overwrite the instruction.
        imem_ack   = 1'b1;
        imem_rdata = ~word;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_ack_instr", instr, word);
    endtask

    task automatic do_advance(input logic [2:0] sel, input logic [31:0] j, input logic ir);
        pcsel   = sel;
        jt      = j;
        irq     = ir;
        advance = 1'b1;
        m_pc    = ref_next(m_pc, m_instr, sel, j, ir);
        @(negedge clk);
        advance = 1'b0;
        irq     = 1'b0;
        pcsel   = 3'($urandom);
        chk("adv_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        m_pc    = 32'h8000_0000;
        m_instr = 32'h0;
        // Reset held: outputs at reset values every cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        end
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_instr", instr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        do_fetch(32'h8000_0000, 32'h1234_5678, 0);
        do_advance(3'b000, 32'h0, 1'b0);
        do_fetch(32'h8000_0004, 32'h0000_0000, 1);
        do_advance(3'b010, 32'h0000_0100, 1'b0);
        do_fetch(32'h0000_0100, 32'h0000_FFFE, 2);
        do_advance(3'b001, 32'h0, 1'b0);
        do_fetch(32'h0000_00FC, 32'h0, 0);
        do_advance(3'b010, 32'h0000_0040, 1'b0);
        do_fetch(32'h0000_0040, 32'h0, 0);
        do_advance(3'b010, 32'h8000_0123, 1'b0);
        do_fetch(32'h0000_0120, 32'h0, 0);
        do_advance(3'b100, 32'h0, 1'b0);
        do_fetch(32'h8000_0008, 32'h0, 0);
        do_advance(3'b010, 32'h8000_0040, 1'b0);
        do_fetch(32'h8000_0040, 32'h0, 0);
        do_advance(3'b010, 32'h8000_0123, 1'b0);
        do_fetch(32'h8000_0120, 32'h0, 0);
        do_advance(3'b010, 32'h0000_0200, 1'b0);
        do_fetch(32'h0000_0200, 32'h0000_0010, 0);
        do_advance(3'b001, 32'h0, 1'b1);
        do_fetch(32'h8000_0008, 32'h0, 0);
        do_advance(3'b010, 32'h8000_0200, 1'b0);
        do_fetch(32'h8000_0200, 32'h0000_0010, 0);
        do_advance(3'b001, 32'h0, 1'b1);
        do_fetch(32'h8000_0244, 32'h0, 3);
        do_advance(3'b110, 32'h0, 1'b0);
        do_fetch(32'h8000_0004, 32'h0, 0);
        do_advance(3'b010, 32'h0000_0300, 1'b0);

        // Reset in the middle of a stalled fetch; the late ACK must be ignored.
        chk("mid_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        reset_n    = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_pc", pc, 32'h8000_0000);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("midrst_instr", instr, 32'h0);
        reset_n = 1'b1;
        m_pc    = 32'h8000_0000;
        m_instr = 32'h0;
        @(negedge clk);

        // Randomized instruction stream against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            logic [2:0]  s;
            w = $urandom;
            s = 3'($urandom_range(0, 7));
            do_fetch(m_pc, w, $urandom_range(0, 3));
            do_advance(s, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
